// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I sequencer: FSM states, op classes, mux selects.
// Decoder op layout: bit5 type, bit4 load/store, bit3 ALU, bits 2:0 jump subcode.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } op_class_t;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_ALU   = 2'd2;

    localparam logic [2:0] WB_SRC_ALU   = 3'd0;
    localparam logic [2:0] WB_SRC_MDR   = 3'd1;
    localparam logic [2:0] WB_SRC_PC4   = 3'd2;
    localparam logic [2:0] WB_SRC_IMM   = 3'd3;
    localparam logic [2:0] WB_SRC_PCIMM = 3'd4;

    localparam int OP_ALU_BIT  = 3;
    localparam int OP_LS_BIT   = 4;
    localparam int OP_TYPE_BIT = 5;

    localparam logic [2:0] OP_GRP_JUMP   = 3'b000;
    localparam logic [2:0] OP_GRP_LOAD   = 3'b010;
    localparam logic [2:0] OP_GRP_BRANCH = 3'b100;
    localparam logic [2:0] OP_GRP_STORE  = 3'b110;

    localparam logic [2:0] OP_SUB_JALR  = 3'b100;
    localparam logic [2:0] OP_SUB_JAL   = 3'b101;
    localparam logic [2:0] OP_SUB_AUIPC = 3'b010;
    localparam logic [2:0] OP_SUB_LUI   = 3'b110;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Datapath/memory side of the multicycle sequencer: strobes, req/ack handshakes, counters.
// master = sequencer, slave = datapath and memories.
interface multicycle_ctrl_if;
    logic        run;
    logic [5:0]  op;
    logic        branch_taken;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        mdr_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        rf_we;
    logic [2:0]  wb_src;
    logic        retire;
    logic        illegal;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    modport master (
        input  run, op, branch_taken, imem_ack, dmem_ack,
        output imem_req, ir_we, dmem_req, dmem_we, mdr_we, pc_we, pc_src,
               rf_we, wb_src, retire, illegal, cycle_cnt, instret_cnt
    );

    modport slave (
        output run, op, branch_taken, imem_ack, dmem_ack,
        input  imem_req, ir_we, dmem_req, dmem_we, mdr_we, pc_we, pc_src,
               rf_we, wb_src, retire, illegal, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/multicycle_ctrl_op_classify.sv
// Combinational 6-bit decoder op to instruction class plus illegal flag; zero latency.
module op_classify
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    output op_class_t  cls,
    output logic       illegal
);
    always_comb begin
        cls     = CLS_NOP;
        illegal = 1'b0;
        if (op == 6'd0) begin
            cls = CLS_NOP;
        end else if (op[OP_ALU_BIT]) begin
            cls = CLS_ALU;
        end else begin
            case (op[OP_TYPE_BIT:OP_ALU_BIT])
                OP_GRP_LOAD:   cls = CLS_LOAD;
                OP_GRP_STORE:  cls = CLS_STORE;
                OP_GRP_BRANCH: cls = CLS_BRANCH;
                OP_GRP_JUMP: begin
                    case (op[2:0])
                        OP_SUB_JALR:  cls = CLS_JALR;
                        OP_SUB_JAL:   cls = CLS_JAL;
                        OP_SUB_AUIPC: cls = CLS_AUIPC;
                        OP_SUB_LUI:   cls = CLS_LUI;
                        default:      illegal = 1'b1;
                    endcase
                end
                default: illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer; 4 cycles per instruction, 5 for load/store, plus memory waits.
// Holds in FETCH/MEM until ack (no timeout); optional counters under MCTRL_PERF_CNT_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SRC = 2'd0
)(
    input  logic             clk,
    input  logic             rst_n,
    multicycle_ctrl_if.master bus
);
    state_t    state_q, state_d;
    op_class_t cls_q, dec_cls;
    logic      dec_illegal;

    op_classify u_classify (
        .op      (bus.op),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_NOP;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) cls_q <= dec_cls;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.mdr_we   = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_src   = PC_SRC_PLUS4;
        bus.rf_we    = 1'b0;
        bus.wb_src   = WB_SRC_ALU;
        bus.retire   = 1'b0;
        bus.illegal  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.pc_src = RESET_PC_SRC;
                if (bus.run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    bus.ir_we = 1'b1;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                state_d = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (cls_q == CLS_STORE);
                if (bus.dmem_ack) begin
                    bus.mdr_we = (cls_q == CLS_LOAD);
                    state_d    = ST_WB;
                end
            end
            ST_WB: begin
                bus.pc_we  = 1'b1;
                bus.retire = 1'b1;
                case (cls_q)
                    CLS_ALU:    begin bus.rf_we = 1'b1; bus.wb_src = WB_SRC_ALU;   end
                    CLS_LOAD:   begin bus.rf_we = 1'b1; bus.wb_src = WB_SRC_MDR;   end
                    CLS_BRANCH: bus.pc_src = bus.branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                    CLS_JAL:    begin bus.rf_we = 1'b1; bus.wb_src = WB_SRC_PC4; bus.pc_src = PC_SRC_IMM; end
                    CLS_JALR:   begin bus.rf_we = 1'b1; bus.wb_src = WB_SRC_PC4; bus.pc_src = PC_SRC_ALU; end
                    CLS_LUI:    begin bus.rf_we = 1'b1; bus.wb_src = WB_SRC_IMM;   end
                    CLS_AUIPC:  begin bus.rf_we = 1'b1; bus.wb_src = WB_SRC_PCIMM; end
                    default:    bus.rf_we = 1'b0;
                endcase
                // run is only looked at here and in IDLE, so an instruction always completes
                state_d = bus.run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: bus.illegal = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MCTRL_PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            if (state_q != ST_IDLE && state_q != ST_TRAP) cycle_q <= cycle_q + 32'd1;
            if (state_q == ST_WB) instret_q <= instret_q + 32'd1;
        end
    end

    assign bus.cycle_cnt   = cycle_q;
    assign bus.instret_cnt = instret_q;
`else
    assign bus.cycle_cnt   = 32'd0;
    assign bus.instret_cnt = 32'd0;
`endif

endmodule
